// File: rtl/alu_mut_pkg.sv
// Shared definitions for the ALU mutation sweep controller: default widths,
// opcode encodings and the sequencer state type.
package alu_mut_pkg;

  localparam int W_DEF   = 4;
  localparam int OPW_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_EQ  = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_mask_next.sv
// Finds the lowest enabled opcode strictly above `cur` (cur is signed, so
// cur = -1 yields the first enabled opcode); none_left flags an empty search.
module alu_op_mask_next #(
  parameter int OPW = 3
) (
  input  logic [2**OPW-1:0] mask,
  input  logic [OPW:0]      cur,
  output logic [OPW-1:0]    next_op,
  output logic              none_left
);

  // Scan top-down so the lowest qualifying opcode is the one that sticks.
  always_comb begin
    next_op   = '0;
    none_left = 1'b1;
    for (int n = 2**OPW - 1; n >= 0; n--) begin
      if (mask[n] && (n > int'($signed(cur)))) begin
        next_op   = OPW'(n);
        none_left = 1'b0;
      end else begin
        next_op   = next_op;
        none_left = none_left;
      end
    end
  end

endmodule

// File: rtl/alu_mutation_sweep_ctrl.sv
// Sweeps every enabled opcode/operand vector into a golden and a mutant ALU,
// counts mismatches and captures the first failing vector.
module alu_mutation_sweep_ctrl
  import alu_mut_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int OPW = OPW_DEF,
  parameter int CW  = 2*W + OPW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [2**OPW-1:0]   op_mask,
  input  logic                stop_on_first,
  input  logic [W-1:0]        gold_result,
  input  logic                gold_zero,
  input  logic [W-1:0]        mut_result,
  input  logic                mut_zero,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [OPW-1:0]      alu_opcode,
  output logic                busy,
  output logic                done,
  output logic                kill,
  output logic [CW-1:0]       vec_count,
  output logic [CW-1:0]       mismatch_count,
  output logic [W-1:0]        fail_a,
  output logic [W-1:0]        fail_b,
  output logic [OPW-1:0]      fail_opcode,
  output logic [W-1:0]        fail_gold,
  output logic [W-1:0]        fail_mut
);

  localparam logic [W-1:0] OPND_MAX = '1;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [2**OPW-1:0]   mask_r;
  logic                sof_r;

  logic [OPW-1:0]      first_op_s;
  logic                first_none_s;
  logic [OPW-1:0]      nxt_op_s;
  logic                nxt_none_s;
  logic                mis_s;
  logic                opnd_last_s;
  logic                end_s;

  alu_op_mask_next #(.OPW(OPW)) u_first (
    .mask      (op_mask),
    .cur       ('1),
    .next_op   (first_op_s),
    .none_left (first_none_s)
  );

  alu_op_mask_next #(.OPW(OPW)) u_next (
    .mask      (mask_r),
    .cur       ({1'b0, alu_opcode}),
    .next_op   (nxt_op_s),
    .none_left (nxt_none_s)
  );

  assign mis_s       = (gold_result != mut_result) || (gold_zero != mut_zero);
  assign opnd_last_s = (alu_a == OPND_MAX) && (alu_b == OPND_MAX);
  assign end_s       = (opnd_last_s && nxt_none_s) || (mis_s && sof_r);

  // Next-state selection; abort beats end-of-sweep, start only outside RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = first_none_s ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (end_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == ST_RUN);
      done    <= (state_nxt_s == ST_DONE);
    end
  end

  // Vector generator, statistics and first-mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r         <= '0;
      sof_r          <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_opcode     <= '0;
      kill           <= 1'b0;
      vec_count      <= '0;
      mismatch_count <= '0;
      fail_a         <= '0;
      fail_b         <= '0;
      fail_opcode    <= '0;
      fail_gold      <= '0;
      fail_mut       <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_count      <= '0;
            mismatch_count <= '0;
            kill           <= 1'b0;
            if (!first_none_s) begin
              mask_r      <= op_mask;
              sof_r       <= stop_on_first;
              alu_opcode  <= first_op_s;
              alu_a       <= '0;
              alu_b       <= '0;
              fail_a      <= '0;
              fail_b      <= '0;
              fail_opcode <= '0;
              fail_gold   <= '0;
              fail_mut    <= '0;
            end
          end
        end
        ST_RUN: begin
          if (!abort) begin
            vec_count <= vec_count + CW'(1);
            if (mis_s) begin
              mismatch_count <= mismatch_count + CW'(1);
              kill           <= 1'b1;
              if (!kill) begin
                fail_a      <= alu_a;
                fail_b      <= alu_b;
                fail_opcode <= alu_opcode;
                fail_gold   <= gold_result;
                fail_mut    <= mut_result;
              end
            end
            // The final vector stays on the ALU inputs once the sweep ends.
            if (!end_s) begin
              alu_b <= alu_b + W'(1);
              if (alu_b == OPND_MAX) begin
                alu_a <= alu_a + W'(1);
              end
              if (opnd_last_s) begin
                alu_opcode <= nxt_op_s;
              end
            end
          end
        end
        default: begin
          mask_r <= mask_r;
        end
      endcase
    end
  end

endmodule
